// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low gfedcba codes,
// the fully blanked cathode pattern and the legal digit-count limit.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n holds the code for nibble n.
  localparam logic [15:0][6:0] SEG_CODES = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic int max_num_digits();
    return 8;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Nibble to active-low gfedcba decoder. Define SEG_HEX_EN to show A-F;
// otherwise nibbles 10..15 are blank.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    seg = SEG_OFF;
`ifdef SEG_HEX_EN
    seg = SEG_CODES[nibble];
`else
    if (nibble <= 4'd9) seg = SEG_CODES[nibble];
`endif
  end

endmodule

// File: rtl/seven_seg_scan_n.sv
// N-digit multiplexed seven-segment driver with per-frame snapshot, blink and dp.
// Optional hex glyphs via SEG_HEX_EN (handled in seven_seg_decode).
module seven_seg_scan_n
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blink_in,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [7:0]                seg,
  output logic                      scan_wrap
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int RC_W  = $clog2(REFRESH_DIV);
  localparam int BC_W  = $clog2(BLINK_DIV);

  if (NUM_DIGITS < 2 || NUM_DIGITS > max_num_digits()) begin : g_bad_num_digits
    $error("seven_seg_scan_n: NUM_DIGITS out of range");
  end
  if (REFRESH_DIV < 2 || BLINK_DIV < 2) begin : g_bad_div
    $error("seven_seg_scan_n: REFRESH_DIV and BLINK_DIV must be >= 2");
  end

  logic [RC_W-1:0]                refresh_cnt;
  logic [BC_W-1:0]                blink_cnt;
  logic [IDX_W-1:0]               index;
  logic                           blink_phase;
  logic                           load_pending;
  logic [NUM_DIGITS-1:0][3:0]     digit_snap;
  logic [NUM_DIGITS-1:0]          dp_snap;
  logic [NUM_DIGITS-1:0]          blink_snap;

  logic                           tick;
  logic                           last_digit;
  logic                           load_snap;
  logic [6:0]                     dec_seg;
  logic [NUM_DIGITS-1:0]          an_next;
  logic [7:0]                     seg_next;

  assign tick       = (refresh_cnt == RC_W'(REFRESH_DIV - 1));
  assign last_digit = (index == IDX_W'(NUM_DIGITS - 1));
  assign load_snap  = load_pending || (tick && last_digit);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      index       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      refresh_cnt <= tick ? '0 : refresh_cnt + RC_W'(1);
      if (tick) index <= last_digit ? '0 : index + IDX_W'(1);
      if (blink_cnt == BC_W'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BC_W'(1);
      end
    end
  end

  // NOTE: snapshot regs are reset so the first blanked frame never shows X data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_snap   <= '0;
      dp_snap      <= '0;
      blink_snap   <= '0;
      load_pending <= 1'b1;
      scan_wrap    <= 1'b0;
    end else begin
      load_pending <= 1'b0;
      scan_wrap    <= load_snap;
      if (load_snap) begin
        digit_snap <= digits_in;
        dp_snap    <= dp_in;
        blink_snap <= blink_in;
      end
    end
  end

  seven_seg_decode u_decode (
    .nibble (digit_snap[index]),
    .seg    (dec_seg)
  );

  // Slot 0 of every digit is a dead cycle to suppress ghosting between anodes.
  always_comb begin
    an_next  = '1;
    seg_next = SEG_BLANK;
    if (en && refresh_cnt != '0 && !(blink_snap[index] && blink_phase)) begin
      an_next  = ~(NUM_DIGITS'(1) << index);
      seg_next = {~dp_snap[index], dec_seg};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule
